// File: rtl/sti_dac_gen_pkg.sv
// Shared types and helpers for the STI/DAC serial transmitter and pixel writer.
// Holds the FSM state encoding, field-length decode and parameter legality check.
package sti_dac_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_FLUSH = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int BYTE_W = 8;

    // Field length in bits for a pi_length code (code 0 = one byte).
    function automatic int field_bits(input int code);
        return BYTE_W * (code + 1);
    endfunction

    function automatic bit params_legal(input int in_w, input int pix_w,
                                        input int max_bytes, input int len_w);
        return (in_w > 0) && (in_w % BYTE_W == 0) &&
               ((pix_w == 8) || (pix_w == 16)) &&
               (max_bytes > 0) && ((1 << len_w) >= max_bytes);
    endfunction

endpackage

// File: rtl/sti_pixel_packer.sv
// Packs the serial bit stream into PIX_W-bit pixels and writes them out,
// including the partial-pixel flush, zero fill of the remaining addresses and finish.
module sti_pixel_packer
    import sti_dac_gen_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              flush,
    input  logic              fill,
    output logic              pcnt_nz,
    output logic              last_wr,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              pixel_finish
);

    localparam int PCW = $clog2(PIX_W);
    localparam logic [PCW-1:0]    PCNT_MAX = PCW'(PIX_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    logic [PCW-1:0]    pcnt_q, pcnt_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  dout_q, dout_d;
    logic              fin_q, fin_d;

    logic [PCW-1:0]    slot;
    logic [PIX_W-1:0]  pix_ins;
    logic [PIX_W-1:0]  wdata;
    logic              wr_req;
    logic              wr_en;

    // PIX_W is a power of two, so PIX_W-1-pcnt is simply the bitwise inverse.
    assign slot = ~pcnt_q;

    always_comb begin
        pcnt_d  = pcnt_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        fin_d   = fin_q;
        wr_req  = 1'b0;
        wdata   = pix_q;
        pix_ins = pix_q;
        pix_ins[slot] = bit_in;

        if (bit_valid) begin
            if (pcnt_q == PCNT_MAX) begin
                wr_req = 1'b1;
                wdata  = pix_ins;
                pcnt_d = '0;
                pix_d  = '0;
            end else begin
                pcnt_d = pcnt_q + PCW'(1);
                pix_d  = pix_ins;
            end
        end else if (flush) begin
            // Unfilled LSBs are already zero because the register clears after every write.
            wr_req = 1'b1;
            wdata  = pix_q;
            pcnt_d = '0;
            pix_d  = '0;
        end else if (fill) begin
            wr_req = 1'b1;
            wdata  = '0;
        end

        wr_en = wr_req & ~fin_q;

        if (wr_en) begin
            dout_d = wdata;
            if (addr_q == ADDR_MAX) begin
                fin_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
            pix_q  <= '0;
            addr_q <= '0;
            dout_q <= '0;
            fin_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            pix_q  <= pix_d;
            addr_q <= addr_d;
            dout_q <= dout_d;
            fin_q  <= fin_d;
        end
    end

    assign pcnt_nz       = |pcnt_q;
    assign last_wr       = wr_en && (addr_q == ADDR_MAX);
    assign pixel_wr      = wr_en;
    assign pixel_addr    = addr_q;
    assign pixel_dataout = wr_en ? wdata : dout_q;
    assign pixel_finish  = fin_q;

endmodule

// File: rtl/sti_dac_gen.sv
// STI/DAC generator top: field aligner, serialiser and sequencing FSM.
// Optional even-parity trailer bit is enabled by defining STI_PARITY_EN.
//
// state    | meaning
// IDLE     | ready for a load word or pi_end
// SHIFT    | serialising the latched field (plus parity bit when enabled)
// FLUSH    | writing the partial pixel left at end of stream
// FILL     | writing zero pixels up to the last address
// DONE     | all addresses written; absorbing until reset
module sti_dac_gen
    import sti_dac_gen_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = 2,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    output logic              pi_ready,
    input  logic [IN_W-1:0]   pi_data,
    input  logic [LEN_W-1:0]  pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              so_data,
    output logic              so_valid,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              pixel_finish
);

    localparam int FW = BYTE_W * MAX_BYTES;
    localparam int AW = (IN_W > FW) ? IN_W : FW;
    localparam int CW = $clog2(FW + 2);
`ifdef STI_PARITY_EN
    localparam int PAR_CYC = 1;
`else
    localparam int PAR_CYC = 0;
`endif

    if (!params_legal(IN_W, PIX_W, MAX_BYTES, LEN_W)) begin : g_bad_params
        $error("sti_dac_gen: illegal parameter combination");
    end

    state_e          state_q, state_d;
    logic [FW-1:0]   sh_q, sh_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            msb_q, msb_d;
    logic            par_q, par_d;

    int              len_bits;
    logic [AW-1:0]   d_ext, mask_l, f_al;
    logic [FW-1:0]   field;
    logic [FW-1:0]   sh_load;
    logic [CW-1:0]   rem_load;

    logic            par_cycle;
    logic            bit_valid;
    logic            serial_bit;
    logic            pcnt_nz;
    logic            last_wr;
    logic            done_hit;

    // Field aligner: result is right-justified, F[L-1:0].
    always_comb begin
        len_bits = field_bits(int'(pi_length));
        d_ext    = AW'(pi_data);
        mask_l   = ~({AW{1'b1}} << len_bits);
        if (len_bits == IN_W) begin
            f_al = d_ext;
        end else if (len_bits < IN_W) begin
            f_al = pi_low ? (d_ext & mask_l) : (d_ext >> (IN_W - len_bits));
        end else begin
            f_al = pi_fill ? (d_ext << (len_bits - IN_W)) : d_ext;
        end
    end

    assign field    = f_al[FW-1:0];
    // MSB-first fields are left-justified so the output tap is always sh_q[FW-1].
    assign sh_load  = pi_msb ? (field << (FW - len_bits)) : field;
    assign rem_load = CW'(len_bits - 1 + PAR_CYC);

`ifdef STI_PARITY_EN
    assign par_cycle = (state_q == ST_SHIFT) && (rem_q == '0);
`else
    assign par_cycle = 1'b0;
`endif

    assign done_hit = last_wr | pixel_finish;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        msb_d   = msb_q;
        par_d   = par_q;

        case (state_q)
            ST_IDLE: begin
                if (pi_end) begin
                    state_d = pcnt_nz ? ST_FLUSH : ST_FILL;
                end else if (load) begin
                    sh_d    = sh_load;
                    rem_d   = rem_load;
                    msb_d   = pi_msb;
                    par_d   = ^field;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!par_cycle) begin
                    sh_d = msb_q ? (sh_q << 1) : (sh_q >> 1);
                end
                if (rem_q == '0) begin
                    state_d = done_hit ? ST_DONE : ST_IDLE;
                end else begin
                    rem_d = rem_q - CW'(1);
                end
            end
            ST_FLUSH: begin
                state_d = last_wr ? ST_DONE : ST_FILL;
            end
            ST_FILL: begin
                if (last_wr) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            rem_q   <= '0;
            msb_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            msb_q   <= msb_d;
            par_q   <= par_d;
        end
    end

    assign pi_ready   = (state_q == ST_IDLE);
    assign so_valid   = (state_q == ST_SHIFT);
    assign serial_bit = msb_q ? sh_q[FW-1] : sh_q[0];
    assign so_data    = so_valid & (par_cycle ? par_q : serial_bit);
    assign bit_valid  = so_valid & ~par_cycle;

    sti_pixel_packer #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk           (clk),
        .reset         (reset),
        .bit_valid     (bit_valid),
        .bit_in        (serial_bit),
        .flush         (state_q == ST_FLUSH),
        .fill          (state_q == ST_FILL),
        .pcnt_nz       (pcnt_nz),
        .last_wr       (last_wr),
        .pixel_wr      (pixel_wr),
        .pixel_addr    (pixel_addr),
        .pixel_dataout (pixel_dataout),
        .pixel_finish  (pixel_finish)
    );

endmodule

// File: tb/tb_sti_dac_gen.sv
// Directed self-checking bench for sti_dac_gen: an 8-bit-pixel instance and a
// 16-bit-pixel instance share the stimulus; each scenario task checks its own results.
module tb_sti_dac_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load, pi_fill, pi_msb, pi_low, pi_end;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;

    logic        pi_ready, so_data, so_valid, pixel_wr, pixel_finish;
    logic [7:0]  pixel_addr, pixel_dataout;

    logic        r16, sd16, sv16, wr16, fin16;
    logic [7:0]  addr16;
    logic [15:0] dout16;

    int total = 0;
    int bad   = 0;
    int idle_bad = 0;

`ifdef STI_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       so_q[$];
    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] wa16_q[$];
    logic [15:0] wd16_q[$];

    sti_dac_gen u_dut (
        .clk(clk), .reset(reset), .load(load), .pi_ready(pi_ready),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_data(so_data), .so_valid(so_valid), .pixel_wr(pixel_wr),
        .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout),
        .pixel_finish(pixel_finish)
    );

    sti_dac_gen #(.PIX_W(16)) u_dut16 (
        .clk(clk), .reset(reset), .load(load), .pi_ready(r16),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_data(sd16), .so_valid(sv16), .pixel_wr(wr16),
        .pixel_addr(addr16), .pixel_dataout(dout16),
        .pixel_finish(fin16)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (so_valid) so_q.push_back(so_data);
            else if (so_data !== 1'b0) idle_bad++;
            if (pixel_wr) begin
                wa_q.push_back(pixel_addr);
                wd_q.push_back(pixel_dataout);
            end
            if (wr16) begin
                wa16_q.push_back(addr16);
                wd16_q.push_back(dout16);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required natural finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        so_q.delete();
        wa_q.delete();
        wd_q.delete();
        wa16_q.delete();
        wd16_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; pi_end = 1'b0;
        pi_data = 16'h0; pi_length = 2'd0; pi_fill = 1'b0; pi_msb = 1'b1; pi_low = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_q();
    endtask

    // Present one word for a single accepting cycle, then scramble the inputs.
    task automatic send(input logic [15:0] d, input logic [1:0] len,
                        input logic fill, input logic msb, input logic low);
        load = 1'b1; pi_data = d; pi_length = len;
        pi_fill = fill; pi_msb = msb; pi_low = low;
        tick();
        load = 1'b0; pi_data = ~d; pi_length = ~len;
        pi_fill = ~fill; pi_msb = ~msb; pi_low = ~low;
    endtask

    task automatic end_stream();
        pi_end = 1'b1;
        tick();
        pi_end = 1'b0;
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int n = 0;
        while (!pi_ready && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (pi_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s: pi_ready=%b after %0d cycles, required 1", tag, pi_ready, budget);
        end
    endtask

    task automatic wait_finish(input int budget, input logic use16, input string tag);
        int n = 0;
        while (!(use16 ? fin16 : pixel_finish) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if ((use16 ? fin16 : pixel_finish) !== 1'b1) begin
            bad++;
            $display("FAIL %s: pixel_finish=0 after %0d cycles, required 1", tag, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({pi_ready, so_valid, so_data, pixel_wr, pixel_finish, pixel_addr, pixel_dataout}
            !== {1'b1, 4'b0, 8'h00, 8'h00}) begin
            bad++;
            $display("FAIL reset8: rdy=%b sv=%b sd=%b wr=%b fin=%b addr=%h dout=%h, required 1 0 0 0 0 00 00",
                     pi_ready, so_valid, so_data, pixel_wr, pixel_finish, pixel_addr, pixel_dataout);
        end
        total++;
        if ({r16, sv16, sd16, wr16, fin16, addr16, dout16} !== {1'b1, 4'b0, 8'h00, 16'h0000}) begin
            bad++;
            $display("FAIL reset16: rdy=%b sv=%b wr=%b addr=%h dout=%h, required 1 0 0 00 0000",
                     r16, sv16, wr16, addr16, dout16);
        end
    endtask

    task automatic test_msb_high();
        logic [7:0] exp = 8'hA5;
        do_reset();
        send(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (so_valid !== 1'b1 || so_data !== exp[7-i]) begin
                bad++;
                $display("FAIL msb_bit%0d: valid=%b data=%b, required valid=1 data=%b",
                         i, so_valid, so_data, exp[7-i]);
            end
            if (i == 7) begin
                total++;
                if ({pixel_wr, pixel_addr, pixel_dataout} !== {1'b1, 8'h00, 8'hA5}) begin
                    bad++;
                    $display("FAIL msb_pixel: wr=%b addr=%h data=%h, required 1 00 a5",
                             pixel_wr, pixel_addr, pixel_dataout);
                end
            end
            tick();
        end
        repeat (PAR) tick();
        total++;
        if ({so_valid, pi_ready, pixel_addr, pixel_dataout} !== {1'b0, 1'b1, 8'h01, 8'hA5}) begin
            bad++;
            $display("FAIL msb_after: sv=%b rdy=%b addr=%h dout=%h, required 0 1 01 a5",
                     so_valid, pi_ready, pixel_addr, pixel_dataout);
        end
    endtask

    task automatic test_lsb_low();
        logic [7:0] exp_bits = 8'b1011_0100;  // stream 0,0,1,0,1,1,0,1 read from bit 0 up
        int errs = 0;
        do_reset();
        send(16'h12B4, 2'd0, 1'b0, 1'b0, 1'b1);
        wait_ready(40, "lsb_ready");
        total++;
        if (so_q.size() != 8 + PAR) begin
            bad++;
            $display("FAIL lsb_count: bits=%0d, required %0d", so_q.size(), 8 + PAR);
        end else begin
            for (int i = 0; i < 8; i++) if (so_q[i] !== exp_bits[i]) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL lsb_stream: %0d wrong bits, required 0", errs);
            end
        end
        total++;
        if (wd_q.size() != 1 || wd_q[0] !== 8'h2D || wa_q[0] !== 8'h00) begin
            bad++;
            $display("FAIL lsb_pixel: writes=%0d first=%h, required 1 write of 2d at 00",
                     wd_q.size(), (wd_q.size() > 0) ? wd_q[0] : 8'hxx);
        end
    endtask

    task automatic test_fields();
        logic [7:0] exp_d[6] = '{8'h80, 8'h01, 8'hA5, 8'hC3, 8'h00, 8'h00};
        int errs = 0;
        do_reset();
        send(16'h8001, 2'd1, 1'b0, 1'b0, 1'b0);
        wait_ready(60, "fields_ready1");
        send(16'hA5C3, 2'd3, 1'b1, 1'b1, 1'b0);
        wait_ready(60, "fields_ready2");
        total++;
        if (wd_q.size() != 6) begin
            bad++;
            $display("FAIL fields_count: writes=%0d, required 6", wd_q.size());
        end else begin
            for (int i = 0; i < 6; i++)
                if (wd_q[i] !== exp_d[i] || wa_q[i] !== 8'(i)) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL fields_data: %0d wrong writes, required 0 (80 01 a5 c3 00 00)", errs);
            end
        end
    endtask

    task automatic test_fill_finish();
        int errs = 0;
        do_reset();
        send(16'hA5C3, 2'd2, 1'b0, 1'b1, 1'b0);
        wait_ready(60, "fill_ready");
        total++;
        if (wd_q.size() != 3 || wd_q[0] !== 8'h00 || wd_q[1] !== 8'hA5 || wd_q[2] !== 8'hC3
            || pixel_finish !== 1'b0 || pixel_addr !== 8'h03) begin
            bad++;
            $display("FAIL fill_words: writes=%0d addr=%h fin=%b, required 00 a5 c3 addr 03 fin 0",
                     wd_q.size(), pixel_addr, pixel_finish);
        end
        end_stream();
        wait_finish(400, 1'b0, "fill_finish");
        total++;
        if (wd_q.size() != 256) begin
            bad++;
            $display("FAIL fill_count: writes=%0d, required 256", wd_q.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                if (wa_q[i] !== 8'(i)) errs++;
                if (i >= 3 && wd_q[i] !== 8'h00) errs++;
            end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL fill_seq: %0d bad addr/data entries, required 0", errs);
            end
        end
        send(16'hFFFF, 2'd0, 1'b0, 1'b1, 1'b0);
        repeat (12) tick();
        total++;
        if ({pi_ready, pixel_finish, pixel_addr} !== {1'b0, 1'b1, 8'hFF} || wd_q.size() != 256
            || so_q.size() != 24 + PAR) begin
            bad++;
            $display("FAIL done_hold: rdy=%b fin=%b addr=%h writes=%0d bits=%0d, required 0 1 ff 256 %0d",
                     pi_ready, pixel_finish, pixel_addr, wd_q.size(), so_q.size(), 24 + PAR);
        end
    endtask

    task automatic test_flush16();
        do_reset();
        send(16'h00A5, 2'd0, 1'b0, 1'b1, 1'b1);
        wait_ready(40, "flush_ready");
        end_stream();
        wait_finish(400, 1'b1, "flush_finish16");
        total++;
        if (wd16_q.size() != 256 || wd16_q[0] !== 16'hA500 || wa16_q[0] !== 8'h00
            || wa16_q[1] !== 8'h01 || wd16_q[1] !== 16'h0000) begin
            bad++;
            $display("FAIL flush16: writes=%0d first=%h@%h, required 256 writes, a500@00 then 0000@01",
                     wd16_q.size(), (wd16_q.size() > 0) ? wd16_q[0] : 16'hxxxx,
                     (wa16_q.size() > 0) ? wa16_q[0] : 8'hxx);
        end
        total++;
        if (wd_q.size() < 2 || wd_q[0] !== 8'hA5 || wa_q[1] !== 8'h01 || wd_q[1] !== 8'h00) begin
            bad++;
            $display("FAIL flush8: writes=%0d, required a5@00 then fill from 01", wd_q.size());
        end
    endtask

    task automatic test_end_wins();
        do_reset();
        load = 1'b1; pi_end = 1'b1; pi_data = 16'hA5C3;
        tick();
        load = 1'b0; pi_end = 1'b0;
        repeat (3) tick();
        total++;
        if (so_q.size() != 0 || pi_ready !== 1'b0 || wa_q.size() < 1 || wa_q[0] !== 8'h00
            || wd_q[0] !== 8'h00) begin
            bad++;
            $display("FAIL end_wins: bits=%0d rdy=%b writes=%0d, required 0 bits, rdy 0, fill from 00",
                     so_q.size(), pi_ready, wa_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(16'hA5C3, 2'd3, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();
        total++;
        if (so_valid !== 1'b1) begin
            bad++;
            $display("FAIL rmid_shift: so_valid=%b, required 1", so_valid);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({so_valid, pi_ready, pixel_wr, pixel_addr} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL rmid_abort: sv=%b rdy=%b wr=%b addr=%h, required 0 1 0 00",
                     so_valid, pi_ready, pixel_wr, pixel_addr);
        end
        reset = 1'b0;
        clear_q();
        send(16'h00A5, 2'd0, 1'b0, 1'b1, 1'b1);
        wait_ready(40, "rmid_ready");
        total++;
        if (wd_q.size() != 1 || wd_q[0] !== 8'hA5 || wa_q[0] !== 8'h00) begin
            bad++;
            $display("FAIL rmid_discard: writes=%0d first=%h, required 1 write of a5 at 00",
                     wd_q.size(), (wd_q.size() > 0) ? wd_q[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(16'h00A5, 2'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8 + PAR; i++) begin
            total++;
            if (so_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_valid%0d: so_valid=%b, required 1", i, so_valid);
            end
            tick();
        end
        total++;
        if ({pi_ready, so_valid} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_gap: rdy=%b sv=%b, required 1 0", pi_ready, so_valid);
        end
        send(16'h003C, 2'd0, 1'b0, 1'b1, 1'b1);
        total++;
        if (so_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: so_valid=%b, required 1", so_valid);
        end
        wait_ready(40, "b2b_ready");
        total++;
        if (wd_q.size() != 2 || wd_q[0] !== 8'hA5 || wd_q[1] !== 8'h3C || wa_q[1] !== 8'h01) begin
            bad++;
            $display("FAIL b2b_pix8: writes=%0d, required a5@00 3c@01", wd_q.size());
        end
        total++;
        if (wd16_q.size() != 1 || wd16_q[0] !== 16'hA53C || wa16_q[0] !== 8'h00) begin
            bad++;
            $display("FAIL b2b_span16: writes=%0d first=%h, required a53c@00",
                     wd16_q.size(), (wd16_q.size() > 0) ? wd16_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_parity();
        do_reset();
        send(16'h00A5, 2'd0, 1'b0, 1'b1, 1'b1);
        wait_ready(40, "par_ready1");
        send(16'h00A4, 2'd0, 1'b0, 1'b1, 1'b1);
        wait_ready(40, "par_ready2");
        total++;
        if (so_q.size() != 2 * (8 + PAR)) begin
            bad++;
            $display("FAIL par_count: bits=%0d, required %0d", so_q.size(), 2 * (8 + PAR));
        end else begin
`ifdef STI_PARITY_EN
            total++;
            if (so_q[8] !== 1'b0 || so_q[17] !== 1'b1) begin
                bad++;
                $display("FAIL par_bits: a5 par=%b a4 par=%b, required 0 1", so_q[8], so_q[17]);
            end
`else
            total++;
            if (so_q[7] !== 1'b1 || so_q[8] !== 1'b1 || so_q[15] !== 1'b0) begin
                bad++;
                $display("FAIL par_bits: b7=%b b8=%b b15=%b, required 1 1 0", so_q[7], so_q[8], so_q[15]);
            end
`endif
        end
        total++;
        if (wd_q.size() != 2 || wd_q[0] !== 8'hA5 || wd_q[1] !== 8'hA4) begin
            bad++;
            $display("FAIL par_pixels: writes=%0d, required a5 a4", wd_q.size());
        end
    endtask

    task automatic test_idle_zero();
        total++;
        if (idle_bad != 0) begin
            bad++;
            $display("FAIL idle_so_data: %0d cycles with so_data=1 while so_valid=0, required 0", idle_bad);
        end
    endtask

    initial begin
        test_reset();
        test_msb_high();
        test_lsb_low();
        test_fields();
        test_fill_finish();
        test_flush16();
        test_end_wins();
        test_reset_mid();
        test_back_to_back();
        test_parity();
        test_idle_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sti_dac_gen.md
Name: sti_dac_gen

Overview:
Parametrised serial-transmit plus pixel-memory writer for the next STI/DAC generation. Accepts one parallel word per load handshake and selects a field of 8/16/24/32 bits, with truncation or zero-fill. It serialises that field MSB- or LSB-first on so_data and packs the same bit stream into PIX_W-bit pixels written to a 2^ADDR_W-entry pixel memory. On pi_end it flushes any partial pixel, zero-fills the remaining addresses, then raises pixel_finish.

Parameters:
IN_W, 16, width of pi_data (multiple of 8)
MAX_BYTES, 4, maximum field length in bytes; field bits L = 8*(pi_length+1)
LEN_W, 2, width of pi_length (clog2 of MAX_BYTES)
PIX_W, 8, pixel width (8 or 16)
ADDR_W, 8, pixel address width; memory depth 2^ADDR_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
load  in  1  word valid; accepted only when pi_ready=1
pi_ready  out  1  block idle, can accept load or pi_end
pi_data  in  IN_W  parallel input word
pi_length  in  LEN_W  field length code: L = 8*(code+1)
pi_fill  in  1  L>IN_W: 1 = data in MSBs, zeros below; 0 = zeros above data
pi_msb  in  1  1 = MSB-first serialisation, 0 = LSB-first
pi_low  in  1  L<IN_W: 1 = take pi_data[L-1:0]; 0 = take pi_data[IN_W-1:IN_W-L]
pi_end  in  1  end of stream; accepted only when pi_ready=1
so_data  out  1  serial bit
so_valid  out  1  serial bit qualifier
pixel_wr  out  1  one-cycle pixel write strobe
pixel_addr  out  ADDR_W  write address
pixel_dataout  out  PIX_W  write data
pixel_finish  out  1  sticky; all addresses written

Behaviour:
- Reset values: all outputs 0, except pi_ready=1. State IDLE. Bit counter 0, pixel register 0. Reset mid-operation aborts immediately and discards the partial pixel.
- States: IDLE, SHIFT, FLUSH, FILL, DONE.
- IDLE, load=1: latch field F (L bits) and go to SHIFT.
  - L==IN_W: F = pi_data.
  - L<IN_W: select per pi_low.
  - L>IN_W: pad per pi_fill.
- IDLE, pi_end=1: go to FLUSH if the pixel bit count is nonzero, else FILL. If pi_end and load are both high, pi_end wins and load is ignored.
- pi_ready=1 only in IDLE. Inputs are sampled only on the accepting cycle; changes afterwards are ignored.
- SHIFT:
  - so_valid=1 for exactly L consecutive cycles, starting the cycle after acceptance.
  - so_data = F[L-1] down to F[0] when pi_msb=1, else F[0] up to F[L-1].
  - Return to IDLE the cycle after the last bit. A new load may be accepted there, giving one idle cycle between words.
- Pixel packing:
  - Each so_valid bit shifts into the pixel register; the first bit of a pixel lands in bit PIX_W-1.
  - In the cycle carrying a pixel's last bit, pixel_wr=1 and pixel_dataout holds the full pixel at the current pixel_addr. pixel_addr increments the following cycle.
  - The pixel bit count persists across words, so a pixel may span words.
- FLUSH: one write of the partial pixel with unfilled LSBs zeroed, then FILL.
- FILL: one write per cycle with pixel_dataout=0, addresses current through 2^ADDR_W-1.
- Final address: after the write to address 2^ADDR_W-1, from any state, pixel_finish=1 and go to DONE.
  - pixel_addr holds at max with no wrap.
  - In SHIFT, serial output completes but no further writes occur.
- DONE: absorbing until reset. pi_ready=0, pixel_wr=0.
- so_data is 0 when so_valid=0. pixel_dataout holds its last value when pixel_wr=0.

Optional Feature:
STI_PARITY_EN.
- Defined: after the L data bits, so_valid stays high one extra cycle and so_data carries the even-parity bit of F. The parity bit is not packed into pixels, and pi_ready returns one cycle later.
- Undefined: no parity cycle, exactly L bits.

Decomposition:
- Package sti_dac_gen_pkg: state enum, byte-length decode constant/function (L from code), parameter legality checks (IN_W%8==0, PIX_W in {8,16}).
- Sub-module sti_pixel_packer: bit counter, pixel shift register, pixel_addr, write strobe, flush/fill/finish logic.
- The top level owns the field aligner, the serialiser and the FSM.

Test Plan:
1. Default params, pi_data=16'hA5C3, len=0, pi_low=0, pi_msb=1, load → so_data 1,0,1,0,0,1,0,1 over 8 cycles; one pixel_wr with dataout 8'hA5, addr 0.
2. pi_data=16'h12B4, len=0, pi_low=1, pi_msb=0 → so_data 0,0,1,0,1,1,0,1; pixel 8'h2D at addr 0.
3. pi_data=16'hA5C3, len=2, pi_fill=0, pi_msb=1 → 24 so_valid cycles; pixels 8'h00, 8'hA5, 8'hC3 at addrs 0,1,2. Then pi_end → 253 zero writes at addrs 3..255, pixel_finish=1 after addr 255, pi_ready=0.
4. PIX_W=16, one 8-bit word 8'hA5 msb-first, then pi_end → flush write 16'hA500 at addr 0, then zero fill from addr 1.
5. load and pi_end high together in IDLE → no so_valid; fill starts at addr 0. Reset asserted mid-SHIFT → so_valid=0 and pi_ready=1 next cycle, addr 0.
6. STI_PARITY_EN, byte 8'hA5 → 9 so_valid cycles, 9th bit 0; with 8'hA4 the 9th bit is 1. Pixel equals data only.
